// File: rtl/fetch_pkg.sv
// Shared types, constants and the line-alignment helper for the fetch sequencer.
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_BOOT      = 3'd0,
    ST_RUN       = 3'd1,
    ST_MISS_REQ  = 3'd2,
    ST_MISS_FILL = 3'd3,
    ST_REPLAY    = 3'd4
  } state_t;

  localparam int WORD_BYTES         = 4;
  localparam int DEFAULT_LINE_WORDS = 4;
  localparam int LINE_OFFSET_BITS   = $clog2(DEFAULT_LINE_WORDS) + 2;

  function automatic int line_offset_bits(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

  // Clears the byte-within-line bits; callers narrow the result to their address width.
  function automatic logic [63:0] line_align(input logic [63:0] addr, input int off_bits);
    logic [63:0] mask;
    mask = ~((64'd1 << off_bits) - 64'd1);
    return addr & mask;
  endfunction

endpackage

// File: rtl/fetch_sequencer_refill_counter.sv
// Refill beat counter: counts delivered words of a line and flags the final beat.
module refill_counter
  import fetch_pkg::*;
#(
  parameter int LINE_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_clr,
  input  logic                          i_inc,
  output logic [$clog2(LINE_WORDS)-1:0] o_count,
  output logic                          o_last
);

  localparam int CW = $clog2(LINE_WORDS);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_count = r_count;
  assign o_last  = (r_count == CW'(LINE_WORDS - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch control FSM: PC/IF-ID steering, redirects, stalls and icache line refill.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] pc_cur,
  input  logic                  stall_id,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic                  jump,
  input  logic [ADDR_WIDTH-1:0] jump_target,
  input  logic                  icache_miss,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  output logic                  pc_write,
  output logic [ADDR_WIDTH-1:0] pc_in,
  output logic                  if_id_write,
  output logic                  flush,
  output logic                  cache_enable,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  fill_we,
  output logic [ADDR_WIDTH-1:0] fill_addr,
  output logic                  busy
);

  localparam int OFF_BITS = line_offset_bits(LINE_WORDS);
  localparam int CW       = $clog2(LINE_WORDS);

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_fetch_pc_d;
  logic [ADDR_WIDTH-1:0] r_line_base;
  logic                  r_pend_vld;
  logic [ADDR_WIDTH-1:0] r_pend_tgt;

  logic                  w_redirect;
  logic [ADDR_WIDTH-1:0] w_target;
  logic [ADDR_WIDTH-1:0] w_pc_plus4;
  logic                  w_latch_base;
  logic                  w_cnt_clr;
  logic                  w_cnt_inc;
  logic [CW-1:0]         w_count;
  logic                  w_last;

  assign w_redirect = branch_taken | jump;
  assign w_target   = branch_taken ? branch_target : jump_target;
  assign w_pc_plus4 = pc_cur + ADDR_WIDTH'(WORD_BYTES);

  refill_counter #(.LINE_WORDS(LINE_WORDS)) u_refill_counter (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (w_cnt_clr),
    .i_inc   (w_cnt_inc),
    .o_count (w_count),
    .o_last  (w_last)
  );

  always_comb begin
    w_next       = r_state;
    w_latch_base = 1'b0;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    pc_write     = 1'b0;
    pc_in        = '0;
    if_id_write  = 1'b0;
    flush        = !stall_id;
    cache_enable = 1'b0;
    mem_req      = 1'b0;
    mem_addr     = '0;
    fill_we      = 1'b0;
    fill_addr    = '0;
    busy         = (r_state != ST_RUN);

    case (r_state)
      ST_BOOT: begin
        cache_enable = 1'b1;
        pc_write     = 1'b1;
        pc_in        = w_pc_plus4;
        w_next       = ST_RUN;
      end
      ST_RUN: begin
        if (w_redirect) begin
          pc_write = 1'b1;
          pc_in    = w_target;
          flush    = 1'b1;
        end else if (icache_miss) begin
          pc_write     = 1'b1;
          pc_in        = r_fetch_pc_d;
          w_latch_base = 1'b1;
          w_next       = ST_MISS_REQ;
        end else begin
          cache_enable = 1'b1;
          pc_write     = !stall_id;
          pc_in        = w_pc_plus4;
          if_id_write  = !stall_id;
          flush        = 1'b0;
        end
      end
      ST_MISS_REQ: begin
        if (w_redirect) begin
          pc_write = 1'b1;
          pc_in    = w_target;
          flush    = 1'b1;
          w_next   = ST_RUN;
        end else begin
          mem_req  = 1'b1;
          mem_addr = r_line_base;
          if (mem_gnt) begin
            w_cnt_clr = 1'b1;
            w_next    = ST_MISS_FILL;
          end
        end
      end
      ST_MISS_FILL: begin
        if (mem_rvalid) begin
          fill_we   = 1'b1;
          fill_addr = r_line_base + ADDR_WIDTH'(w_count) * ADDR_WIDTH'(WORD_BYTES);
          w_cnt_inc = 1'b1;
          if (w_last) w_next = ST_REPLAY;
        end
      end
      ST_REPLAY: begin
        cache_enable = 1'b1;
        pc_write     = 1'b1;
        if (w_redirect) begin
          pc_in = w_target;
          flush = 1'b1;
        end else if (r_pend_vld) begin
          pc_in = r_pend_tgt;
          flush = 1'b1;
        end else begin
          pc_in = w_pc_plus4;
        end
        w_next = ST_RUN;
      end
      default: w_next = ST_BOOT;
    endcase

    // Outputs are combinational, so reset must force them directly rather than wait for the state.
    if (reset) begin
      w_latch_base = 1'b0;
      w_cnt_clr    = 1'b0;
      w_cnt_inc    = 1'b0;
      pc_write     = 1'b0;
      pc_in        = '0;
      if_id_write  = 1'b0;
      flush        = 1'b1;
      cache_enable = 1'b0;
      mem_req      = 1'b0;
      mem_addr     = '0;
      fill_we      = 1'b0;
      fill_addr    = '0;
      busy         = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_BOOT;
      r_fetch_pc_d <= '0;
      r_line_base  <= '0;
      r_pend_vld   <= 1'b0;
      r_pend_tgt   <= '0;
    end else begin
      r_state <= w_next;
      if (cache_enable) r_fetch_pc_d <= pc_cur;
      if (w_latch_base) r_line_base <= ADDR_WIDTH'(line_align(64'(r_fetch_pc_d), OFF_BITS));
      // Redirects arriving mid-fill are parked until REPLAY; the latest one wins.
      if (r_state == ST_MISS_FILL && w_redirect) begin
        r_pend_vld <= 1'b1;
        r_pend_tgt <= w_target;
      end else if (r_state == ST_REPLAY) begin
        r_pend_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed scoreboard bench for fetch_sequencer: boot, miss/refill, redirects, stalls, reset mid-fill.
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic [31:0] pc_cur;
  logic        stall_id;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        icache_miss;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic        pc_write;
  logic [31:0] pc_in;
  logic        if_id_write;
  logic        flush;
  logic        cache_enable;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        fill_we;
  logic [31:0] fill_addr;
  logic        busy;

  typedef struct {
    logic        pw;
    logic [31:0] pcin;
    logic        ifw;
    logic        fl;
    logic        ce;
    logic        req;
    logic [31:0] maddr;
    logic        we;
    logic [31:0] faddr;
    logic        bsy;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp;
  int   n_err;
  int   n_cyc;

  fetch_sequencer #(.ADDR_WIDTH(32), .LINE_WORDS(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_cur        (pc_cur),
    .stall_id      (stall_id),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .icache_miss   (icache_miss),
    .mem_gnt       (mem_gnt),
    .mem_rvalid    (mem_rvalid),
    .pc_write      (pc_write),
    .pc_in         (pc_in),
    .if_id_write   (if_id_write),
    .flush         (flush),
    .cache_enable  (cache_enable),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .fill_we       (fill_we),
    .fill_addr     (fill_addr),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program counter register driven by the sequencer's load controls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_cur <= '0;
    else if (pc_write) pc_cur <= pc_in;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got 0x%0h want 0x%0h", tag, n_cyc, act, exp);
    end
  endtask

  function automatic exp_t ex(input logic pw, input logic [31:0] pcin, input logic ifw,
                              input logic fl, input logic ce, input logic req,
                              input logic [31:0] maddr, input logic we,
                              input logic [31:0] faddr, input logic bsy);
    exp_t e;
    e.pw = pw; e.pcin = pcin; e.ifw = ifw; e.fl = fl; e.ce = ce;
    e.req = req; e.maddr = maddr; e.we = we; e.faddr = faddr; e.bsy = bsy;
    return e;
  endfunction

  function automatic exp_t run(input logic [31:0] pcin);
    return ex(1'b1, pcin, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endfunction

  function automatic exp_t rst_exp();
    return ex(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endfunction

  // One clock: queue the expectation, compare at the falling edge, release pulsed inputs.
  task automatic cyc(input exp_t e);
    exp_t g;
    sb_q.push_back(e);
    @(negedge clk);
    g = sb_q.pop_front();
    chk("pc_write", {31'h0, pc_write}, {31'h0, g.pw});
    if (g.pw) chk("pc_in", pc_in, g.pcin);
    chk("if_id_write", {31'h0, if_id_write}, {31'h0, g.ifw});
    chk("flush", {31'h0, flush}, {31'h0, g.fl});
    chk("cache_enable", {31'h0, cache_enable}, {31'h0, g.ce});
    chk("mem_req", {31'h0, mem_req}, {31'h0, g.req});
    if (g.req) chk("mem_addr", mem_addr, g.maddr);
    chk("fill_we", {31'h0, fill_we}, {31'h0, g.we});
    if (g.we) chk("fill_addr", fill_addr, g.faddr);
    chk("busy", {31'h0, busy}, {31'h0, g.bsy});
    @(posedge clk);
    #1;
    n_cyc++;
    branch_taken = 1'b0;
    jump         = 1'b0;
    icache_miss  = 1'b0;
    mem_gnt      = 1'b0;
    mem_rvalid   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0; n_err = 0; n_cyc = 0;
    reset = 1'b1; stall_id = 1'b0;
    branch_taken = 1'b0; branch_target = 32'h0;
    jump = 1'b0; jump_target = 32'h0;
    icache_miss = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc(rst_exp());
    reset = 1'b0;

    // Boot bubble, then sequential fetch up to 0x1C
    cyc(ex(1'b1, 32'h4, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1));
    for (int a = 4; a <= 32'h1C; a += 4) cyc(run(32'(a + 4)));

    // Miss on 0x1C: rewind, request line 0x10, four beats, replay
    icache_miss = 1'b1;
    cyc(ex(1'b1, 32'h1C, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0));
    cyc(ex(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 1'b1));
    mem_gnt = 1'b1;
    cyc(ex(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 1'b1));
    cyc(ex(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1));
    for (int b = 0; b < 4; b++) begin
      mem_rvalid = 1'b1;
      cyc(ex(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'(32'h10 + 4 * b), 1'b1));
    end
    cyc(ex(1'b1, 32'h20, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1));
    cyc(run(32'h24));

    // Branch and jump together under stall: branch wins, flush forced
    stall_id = 1'b1;
    branch_taken = 1'b1; branch_target = 32'h200;
    jump = 1'b1; jump_target = 32'h300;
    cyc(ex(1'b1, 32'h200, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0));
    stall_id = 1'b0;
    cyc(run(32'h204));
    cyc(run(32'h208));

    // Miss on 0x204, branch to 0x400 during second beat is held until replay
    icache_miss = 1'b1;
    cyc(ex(1'b1, 32'h204, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0));
    mem_gnt = 1'b1;
    cyc(ex(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1));
    for (int b = 0; b < 4; b++) begin
      mem_rvalid = 1'b1;
      if (b == 1) begin
        branch_taken = 1'b1; branch_target = 32'h400;
      end
      cyc(ex(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'(32'h200 + 4 * b), 1'b1));
    end
    cyc(ex(1'b1, 32'h400, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1));
    cyc(run(32'h404));

    // Miss while stalled: no flush, no IF/ID load through the whole refill
    stall_id = 1'b1;
    icache_miss = 1'b1;
    cyc(ex(1'b1, 32'h400, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0));
    mem_gnt = 1'b1;
    cyc(ex(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h400, 1'b0, 32'h0, 1'b1));
    for (int b = 0; b < 4; b++) begin
      mem_rvalid = 1'b1;
      cyc(ex(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'(32'h400 + 4 * b), 1'b1));
    end
    cyc(ex(1'b1, 32'h404, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1));
    stall_id = 1'b0;
    cyc(run(32'h408));

    // Redirect before grant abandons the request
    icache_miss = 1'b1;
    cyc(ex(1'b1, 32'h404, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0));
    cyc(ex(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h400, 1'b0, 32'h0, 1'b1));
    jump = 1'b1; jump_target = 32'h300; mem_gnt = 1'b1;
    cyc(ex(1'b1, 32'h300, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1));
    cyc(run(32'h304));

    // Reset in the middle of a refill, then a fresh miss restarts at beat 0
    icache_miss = 1'b1;
    cyc(ex(1'b1, 32'h300, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0));
    mem_gnt = 1'b1;
    cyc(ex(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h300, 1'b0, 32'h0, 1'b1));
    for (int b = 0; b < 2; b++) begin
      mem_rvalid = 1'b1;
      cyc(ex(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'(32'h300 + 4 * b), 1'b1));
    end
    reset = 1'b1; mem_rvalid = 1'b1;
    cyc(rst_exp());
    reset = 1'b0;
    cyc(ex(1'b1, 32'h4, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1));
    cyc(run(32'h8));
    icache_miss = 1'b1;
    cyc(ex(1'b1, 32'h4, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0));
    mem_gnt = 1'b1;
    cyc(ex(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b1));
    for (int b = 0; b < 2; b++) begin
      mem_rvalid = 1'b1;
      cyc(ex(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'(4 * b), 1'b1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
